// File: rtl/z16_data_ram.sv
// rtl/z16_data_ram.sv - Z16 byte-lane data RAM with req/ack pipeline and post-reset clear sweep
module z16_data_ram #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = 10,
    parameter int LAT        = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req,
    input  logic                  i_wen,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_W/8-1:0]   i_be,
    input  logic [DATA_W-1:0]     i_data,
    output logic                  o_ready,
    output logic                  o_ack,
    output logic                  o_err,
    output logic [DATA_W-1:0]     o_rdata
);
    localparam int NB    = DATA_W / 8;
    localparam int AB    = $clog2(NB);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [ADDR_W-1:0] LO_MASK = ADDR_W'(NB - 1);
    localparam logic [ADDR_W-1:0] HI_MASK = ~ADDR_W'((2 ** (DEPTH_LOG2 + AB)) - 1);

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0]       mem_q [DEPTH];

    logic [LAT-1:0]          vld_q;
    logic [LAT-1:0]          err_q;
    logic [DATA_W-1:0]       rd_q [LAT];

    logic                    ready;
    logic                    accept;
    logic                    bad;
    logic [DEPTH_LOG2-1:0]   widx;

    // Misaligned or beyond the array: acked with an error, never touches memory.
    assign bad    = (|(i_addr & LO_MASK)) | (|(i_addr & HI_MASK));
    assign widx   = i_addr[DEPTH_LOG2+AB-1:AB];
    assign ready  = (state_q == S_IDLE) & ~i_rst;
    assign accept = i_req & ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= (INIT_CLEAR != 0) ? S_CLEAR : S_IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == S_CLEAR) begin
            clr_cnt_d = clr_cnt_q + DEPTH_LOG2'(1);
            if (clr_cnt_q == '1) begin
                state_d = S_IDLE;
            end
        end
    end

    // Array has no reset; the clear sweep and accepted stores share one write port.
    always_ff @(posedge i_clk) begin
        if (state_q == S_CLEAR && !i_rst) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (accept && i_wen && !bad) begin
            for (int b = 0; b < NB; b++) begin
                if (i_be[b]) begin
                    mem_q[widx][8*b +: 8] <= i_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_q <= '0;
            err_q <= '0;
            for (int k = 0; k < LAT; k++) begin
                rd_q[k] <= '0;
            end
        end else begin
            vld_q[0] <= accept;
            err_q[0] <= accept & bad;
            rd_q[0]  <= (accept && !i_wen && !bad) ? mem_q[widx] : '0;
            for (int k = 1; k < LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                err_q[k] <= err_q[k-1];
                rd_q[k]  <= rd_q[k-1];
            end
        end
    end

    assign o_ready = ready;
    assign o_ack   = vld_q[LAT-1];
    assign o_err   = err_q[LAT-1];
    assign o_rdata = rd_q[LAT-1];
endmodule

// File: tb/tb_z16_data_ram.sv
// tb/tb_z16_data_ram.sv - directed vector bench for z16_data_ram at LAT=1 and LAT=3
module tb_z16_data_ram;
    logic        clk = 1'b0;
    logic        rst;
    logic        req, wen;
    logic [15:0] addr, wdata;
    logic [1:0]  be;

    logic        rdy1, ack1, err1;
    logic [15:0] rd1;
    logic        rdy3, ack3, err3;
    logic [15:0] rd3;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wen;
        logic [15:0] addr;
        logic [1:0]  be;
        logic [15:0] data;
        logic        err;
        logic [15:0] rdata;
    } vec_t;

    vec_t vecs[14];
    vec_t burst[4];
    int   burst_n;
    int   cnt;
    logic stray;

    always #5 clk = ~clk;

    z16_data_ram #(.LAT(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_wen(wen), .i_addr(addr),
        .i_be(be), .i_data(wdata), .o_ready(rdy1), .o_ack(ack1), .o_err(err1), .o_rdata(rd1)
    );

    z16_data_ram #(.LAT(3)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_wen(wen), .i_addr(addr),
        .i_be(be), .i_data(wdata), .o_ready(rdy3), .o_ack(ack3), .o_err(err3), .o_rdata(rd3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " ready1"}, 32'(rdy1), 0);
        chk({tag, " ready3"}, 32'(rdy3), 0);
        chk({tag, " ack1"},   32'(ack1), 0);
        chk({tag, " ack3"},   32'(ack3), 0);
        chk({tag, " err1"},   32'(err1), 0);
        chk({tag, " rdata3"}, 32'(rd3),  0);
    endtask

    task automatic wait_ready();
        cnt   = 0;
        stray = 1'b0;
        while (!(rdy1 && rdy3) && cnt < 3000) begin
            @(negedge clk);
            cnt++;
            if (ack1 || ack3) stray = 1'b1;
        end
    endtask

    // Item k is driven at negedge k and accepted on the following posedge;
    // LAT=1 shows it at negedge k+1, LAT=3 at negedge k+3.
    task automatic run_burst();
        int k1, k3;
        for (int c = 0; c <= burst_n + 3; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                k1 = c - 1;
                k3 = c - 3;
                if (k1 < burst_n) begin
                    chk($sformatf("lat1 ack a=%h", burst[k1].addr), 32'(ack1), 1);
                    chk($sformatf("lat1 err a=%h", burst[k1].addr), 32'(err1), 32'(burst[k1].err));
                    chk($sformatf("lat1 rdata a=%h", burst[k1].addr), 32'(rd1), 32'(burst[k1].rdata));
                end else begin
                    chk("lat1 idle ack", 32'(ack1), 0);
                end
                if (k3 >= 0 && k3 < burst_n) begin
                    chk($sformatf("lat3 ack a=%h", burst[k3].addr), 32'(ack3), 1);
                    chk($sformatf("lat3 err a=%h", burst[k3].addr), 32'(err3), 32'(burst[k3].err));
                    chk($sformatf("lat3 rdata a=%h", burst[k3].addr), 32'(rd3), 32'(burst[k3].rdata));
                end else begin
                    chk("lat3 idle ack", 32'(ack3), 0);
                end
            end
            if (c < burst_n) begin
                req   = 1'b1;
                wen   = burst[c].wen;
                addr  = burst[c].addr;
                be    = burst[c].be;
                wdata = burst[c].data;
            end else begin
                req = 1'b0;
            end
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 16'h07FE, 2'b00, 16'h0000, 1'b0, 16'h0000};
        vecs[1]  = '{1'b1, 16'h0010, 2'b11, 16'hBEEF, 1'b0, 16'h0000};
        vecs[2]  = '{1'b1, 16'h0010, 2'b10, 16'h1234, 1'b0, 16'h0000};
        vecs[3]  = '{1'b0, 16'h0010, 2'b00, 16'h0000, 1'b0, 16'h12EF};
        vecs[4]  = '{1'b0, 16'h0011, 2'b00, 16'h0000, 1'b1, 16'h0000};
        vecs[5]  = '{1'b0, 16'h0800, 2'b00, 16'h0000, 1'b1, 16'h0000};
        vecs[6]  = '{1'b1, 16'h0800, 2'b11, 16'hFFFF, 1'b1, 16'h0000};
        vecs[7]  = '{1'b1, 16'h0013, 2'b11, 16'hFFFF, 1'b1, 16'h0000};
        vecs[8]  = '{1'b0, 16'h0010, 2'b00, 16'h0000, 1'b0, 16'h12EF};
        vecs[9]  = '{1'b1, 16'h0000, 2'b00, 16'hFFFF, 1'b0, 16'h0000};
        vecs[10] = '{1'b0, 16'h0000, 2'b00, 16'h0000, 1'b0, 16'h0000};
        vecs[11] = '{1'b0, 16'h0012, 2'b00, 16'h0000, 1'b0, 16'h0000};
        vecs[12] = '{1'b1, 16'h07FE, 2'b01, 16'h8001, 1'b0, 16'h0000};
        vecs[13] = '{1'b0, 16'h07FE, 2'b00, 16'h0000, 1'b0, 16'h0001};

        rst = 1'b1; req = 1'b0; wen = 1'b0; addr = '0; be = '0; wdata = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");

        rst = 1'b0;
        wait_ready();
        chk("clear cycles", 32'(cnt), 1024);
        chk("clear stray ack", 32'(stray), 0);

        for (int i = 0; i < 14; i++) begin
            burst[0] = vecs[i];
            burst_n  = 1;
            run_burst();
        end

        for (int i = 0; i < 4; i++) begin
            burst[i] = '{1'b1, 16'(2 * i), 2'b11, 16'(16'h1111 * (i + 1)), 1'b0, 16'h0000};
        end
        burst_n = 4;
        run_burst();
        for (int i = 0; i < 4; i++) begin
            burst[i] = '{1'b0, 16'(2 * i), 2'b00, 16'h0000, 1'b0, 16'(16'h1111 * (i + 1))};
        end
        run_burst();

        burst[0] = '{1'b1, 16'h0020, 2'b11, 16'hA5C3, 1'b0, 16'h0000};
        burst[1] = '{1'b0, 16'h0020, 2'b00, 16'h0000, 1'b0, 16'hA5C3};
        burst_n  = 2;
        run_burst();

        // Reset with a load in flight on both instances.
        @(negedge clk);
        req = 1'b1; wen = 1'b0; addr = 16'h0010; be = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = 1'b0;
        stray = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ack1 || ack3) stray = 1'b1;
        end
        chk("inflight stray ack", 32'(stray), 0);
        chk_reset_outputs("inflight");

        rst = 1'b0;
        repeat (500) begin
            @(negedge clk);
            if (ack1 || ack3) stray = 1'b1;
        end
        chk("mid clear ready", 32'(rdy1), 0);
        chk("mid clear stray", 32'(stray), 0);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midclear");
        rst = 1'b0;
        req = 1'b1; wen = 1'b1; addr = 16'h0020; be = 2'b11; wdata = 16'hFFFF;
        wait_ready();
        req = 1'b0;
        chk("restart clear cycles", 32'(cnt), 1024);
        chk("held req stray ack", 32'(stray), 0);

        burst[0] = '{1'b0, 16'h0010, 2'b00, 16'h0000, 1'b0, 16'h0000};
        burst[1] = '{1'b0, 16'h0020, 2'b00, 16'h0000, 1'b0, 16'h0000};
        burst[2] = '{1'b0, 16'h0006, 2'b00, 16'h0000, 1'b0, 16'h0000};
        burst_n  = 3;
        run_burst();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end
endmodule
